// File: rtl/pong_scene_renderer.sv
// Pong scene pixel generator: double-buffered object registers, 2-stage render
// pipeline driven by the raster position, and per-frame collision status.
module pong_scene_renderer #(
  parameter int unsigned H_VIS_START = 160,
  parameter int unsigned H_VIS       = 640,
  parameter int unsigned V_VIS       = 480,
  parameter int unsigned BALL_SIZE   = 8,
  parameter int unsigned PAD_W       = 8,
  parameter int unsigned PAD_H       = 64,
  parameter int unsigned PAD_L_X     = 16,
  parameter int unsigned PAD_R_X     = 616
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        frame_start,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [2:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
);

  localparam int unsigned CW = 10;
  localparam int unsigned SW = CW + 1;
  localparam logic [23:0] RGB_BG    = 24'h0C01B5;
  localparam logic [23:0] RGB_BALL  = 24'hFFFFFF;
  localparam logic [23:0] RGB_PAD   = 24'h00FF00;
  localparam logic [23:0] RGB_BLANK = 24'h000000;

  logic [CW-1:0] pend_ball_x, pend_ball_y, pend_pad_l_y, pend_pad_r_y, pend_ctrl;
  logic [CW-1:0] act_ball_x, act_ball_y, act_pad_l_y, act_pad_r_y;
  logic          act_en;

  // CPU writes land in pending; the whole bank is copied to active at frame start
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_ball_x  <= '0;
      pend_ball_y  <= '0;
      pend_pad_l_y <= '0;
      pend_pad_r_y <= '0;
      pend_ctrl    <= '0;
      act_ball_x   <= '0;
      act_ball_y   <= '0;
      act_pad_l_y  <= '0;
      act_pad_r_y  <= '0;
      act_en       <= 1'b0;
    end else begin
      if (wr_en) begin
        case (wr_addr)
          3'd0:    pend_ball_x  <= wr_data[CW-1:0];
          3'd1:    pend_ball_y  <= wr_data[CW-1:0];
          3'd2:    pend_pad_l_y <= wr_data[CW-1:0];
          3'd3:    pend_pad_r_y <= wr_data[CW-1:0];
          3'd4:    pend_ctrl    <= wr_data[CW-1:0];
          default: ;
        endcase
      end
      if (frame_start) begin
        act_ball_x  <= pend_ball_x;
        act_ball_y  <= pend_ball_y;
        act_pad_l_y <= pend_pad_l_y;
        act_pad_r_y <= pend_pad_r_y;
        act_en      <= pend_ctrl[0];
      end
    end
  end

  // Range test widened by one bit so objects near 1023 clip instead of wrapping
  function automatic logic span(input logic [CW-1:0] p, input logic [CW-1:0] lo,
                                input int unsigned len);
    return (p >= lo) && (SW'(p) < SW'(lo) + SW'(len));
  endfunction

  logic [CW-1:0] x_c;
  logic          vis_c, in_ball_c, in_padl_c, in_padr_c;

  always_comb begin
    vis_c     = (SW'(hcount) >= SW'(H_VIS_START)) &&
                (SW'(hcount) <  SW'(H_VIS_START + H_VIS)) &&
                (SW'(vcount) <  SW'(V_VIS));
    x_c       = hcount - CW'(H_VIS_START);
    in_ball_c = span(x_c, act_ball_x, BALL_SIZE) && span(vcount, act_ball_y, BALL_SIZE);
    in_padl_c = span(x_c, CW'(PAD_L_X), PAD_W) && span(vcount, act_pad_l_y, PAD_H);
    in_padr_c = span(x_c, CW'(PAD_R_X), PAD_W) && span(vcount, act_pad_r_y, PAD_H);
  end

  logic s1_valid, s1_vis, s1_en, s1_ball, s1_padl, s1_padr;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_vis   <= 1'b0;
      s1_en    <= 1'b0;
      s1_ball  <= 1'b0;
      s1_padl  <= 1'b0;
      s1_padr  <= 1'b0;
    end else if (pix_en) begin
      s1_valid <= 1'b1;
      s1_vis   <= vis_c;
      s1_en    <= act_en;
      s1_ball  <= in_ball_c;
      s1_padl  <= in_padl_c;
      s1_padr  <= in_padr_c;
    end
  end

  // Colour mux, highest priority first
  always_ff @(posedge clk) begin
    if (rst) begin
      {red, green, blue} <= RGB_BLANK;
    end else if (pix_en) begin
      if (!s1_valid || !s1_vis)     {red, green, blue} <= RGB_BLANK;
      else if (!s1_en)              {red, green, blue} <= RGB_BG;
      else if (s1_ball)             {red, green, blue} <= RGB_BALL;
      else if (s1_padl || s1_padr)  {red, green, blue} <= RGB_PAD;
      else                          {red, green, blue} <= RGB_BG;
    end
  end

  logic [1:0] hit_c, hit_acc, status_hit;
  logic [7:0] frame_cnt;

  always_comb begin
    hit_c[0] = s1_valid && s1_vis && s1_en && s1_ball && s1_padl;
    hit_c[1] = s1_valid && s1_vis && s1_en && s1_ball && s1_padr;
  end

  // Hits seen on the frame_start cycle itself belong to the new frame
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_acc    <= '0;
      status_hit <= '0;
      frame_cnt  <= '0;
    end else if (frame_start) begin
      status_hit <= hit_acc;
      frame_cnt  <= frame_cnt + 8'd1;
      hit_acc    <= hit_c;
    end else begin
      hit_acc    <= hit_acc | hit_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      case (rd_addr)
        3'd0:    rd_data <= 16'(pend_ball_x);
        3'd1:    rd_data <= 16'(pend_ball_y);
        3'd2:    rd_data <= 16'(pend_pad_l_y);
        3'd3:    rd_data <= 16'(pend_pad_r_y);
        3'd4:    rd_data <= 16'(pend_ctrl);
        3'd5:    rd_data <= {frame_cnt, 6'd0, status_hit};
        default: rd_data <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_scene_renderer.sv
// Bench for pong_scene_renderer: directed scenarios plus randomized traffic,
// checked against a raster-level reference model of the scene.
module tb_pong_scene_renderer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b0;
  logic [9:0]  hcount = '0;
  logic [9:0]  vcount = '0;
  logic        frame_start = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [2:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic [7:0]  red, green, blue;

  always #5 clk = ~clk;

  pong_scene_renderer dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
    .frame_start(frame_start), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .red(red), .green(green), .blue(blue)
  );

  localparam logic [23:0] BG = 24'h0C01B5;
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] GREEN = 24'h00FF00;

  // Reference model state
  int          pend[5];
  int          act[5];
  int          fcnt;
  logic [1:0]  hits, acc, s1hit;
  logic [23:0] pipe[$];
  logic [23:0] exp_rgb;
  logic [15:0] exp_rd;
  int          tests = 0;
  int          fails = 0;

  function automatic bit inside_box(int x, int y, int ox, int oy, int w, int h);
    return (x >= ox) && (x < ox + w) && (y >= oy) && (y < oy + h);
  endfunction

  function automatic bit visible(int h, int v);
    return (h >= 160) && (h < 800) && (v < 480);
  endfunction

  function automatic logic [23:0] colour(int h, int v);
    int x = h - 160;
    if (!visible(h, v)) return 24'h0;
    if (act[4] % 2 == 0) return BG;
    if (inside_box(x, v, act[0], act[1], 8, 8)) return WHITE;
    if (inside_box(x, v, 16, act[2], 8, 64) || inside_box(x, v, 616, act[3], 8, 64)) return GREEN;
    return BG;
  endfunction

  function automatic logic [1:0] hit_of(int h, int v);
    int x = h - 160;
    bit b;
    if (!visible(h, v) || act[4] % 2 == 0) return 2'b00;
    b = inside_box(x, v, act[0], act[1], 8, 8);
    return {b && inside_box(x, v, 616, act[3], 8, 64), b && inside_box(x, v, 16, act[2], 8, 64)};
  endfunction

  function automatic logic [15:0] read_model(int a);
    if (a < 5) return 16'(pend[a]);
    if (a == 5) return {8'(fcnt), 6'd0, hits};
    return 16'h0;
  endfunction

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin pend[i] = 0; act[i] = 0; end
    fcnt = 0; hits = 0; acc = 0; s1hit = 0;
    pipe.delete();
    pipe.push_back(24'h0);
    exp_rgb = 0; exp_rd = 0;
  endtask

  // One clock: drive inputs, advance the model on the edge, check #1 later
  task automatic step(input int h, input int v, input bit pe, input bit fs, input bit we,
                      input int wa, input int wd, input int ra, input bit r = 1'b0);
    hcount = 10'(h); vcount = 10'(v); pix_en = pe; frame_start = fs;
    wr_en = we; wr_addr = 3'(wa); wr_data = 16'(wd); rd_addr = 3'(ra); rst = r;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      exp_rd = read_model(ra);
      if (fs) begin
        hits = acc;
        fcnt = (fcnt + 1) % 256;
        acc = s1hit;
      end else begin
        acc = acc | s1hit;
      end
      if (pe) begin
        pipe.push_back(colour(h, v));
        exp_rgb = pipe.pop_front();
        s1hit = hit_of(h, v);
      end
      if (fs) act = pend;
      if (we && wa < 5) pend[wa] = wd & 16'h03FF;
    end
    #1;
    chk("rgb", {red, green, blue}, exp_rgb);
    chk("rd_data", 24'(rd_data), 24'(exp_rd));
  endtask

  task automatic wr(input int a, input int d);
    step(0, 500, 0, 0, 1, a, d, 0);
  endtask

  task automatic px(input int h, input int v);
    step(h, v, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic fstart();
    step(0, 500, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic rd(input int a);
    step(0, 500, 0, 0, 0, 0, 0, a);
  endtask

  logic [23:0] frozen;
  int bx, by, fsave;

  initial begin
    model_reset();
    // Reset with pix_en toggling
    for (int i = 0; i < 4; i++) step(300, 100, i % 2, 0, 0, 0, 0, 5, 1'b1);
    for (int i = 0; i < 3; i++) step(300 + i, 100, i % 2, 0, 0, 0, 0, 5);
    chk("reset_rgb", {red, green, blue}, 24'h0);
    chk("reset_status", 24'(rd_data), 24'h0);

    // Ball render
    wr(0, 100); wr(1, 200); wr(4, 1); fstart();
    px(260, 200); px(268, 200);
    chk("ball_white", {red, green, blue}, WHITE);
    px(100, 200);
    chk("ball_right_edge_bg", {red, green, blue}, BG);
    px(0, 500);
    chk("hblank_black", {red, green, blue}, 24'h0);

    // Double buffering
    wr(0, 300); rd(0);
    chk("rd_pending_ballx", 24'(rd_data), 24'd300);
    px(260, 200); px(460, 200);
    chk("old_bank_ball", {red, green, blue}, WHITE);
    px(0, 500);
    chk("new_pos_not_yet", {red, green, blue}, BG);
    fstart();
    px(460, 200); px(0, 500);
    chk("new_pos_active", {red, green, blue}, WHITE);
    step(0, 500, 0, 1, 1, 0, 50, 0);
    px(210, 200); px(460, 200);
    chk("same_cycle_write_deferred", {red, green, blue}, BG);
    px(0, 500);
    chk("ball_still_300", {red, green, blue}, WHITE);
    fstart();
    px(210, 200); px(0, 500);
    chk("deferred_write_applied", {red, green, blue}, WHITE);

    // Paddle and collision sweep
    wr(2, 180); wr(0, 20); wr(1, 200); fstart();
    for (int v = 170; v <= 250; v++)
      for (int h = 160; h <= 200; h++) px(h, v);
    px(0, 500); px(0, 500);
    fstart(); rd(5);
    chk("status_hit_l", 24'(rd_data[7:0]), 24'h01);
    chk("status_word", 24'(rd_data), 24'(16'h0001 | 16'((fcnt % 256) << 8)));
    px(180, 190); px(183, 204);
    chk("paddle_green", {red, green, blue}, GREEN);
    px(0, 500);
    chk("overlap_white", {red, green, blue}, WHITE);

    // Stall mid-line
    wr(0, 100); fstart();
    px(258, 200); px(259, 200); px(260, 200);
    frozen = {red, green, blue};
    for (int i = 0; i < 5; i++) begin
      step(700, 10, 0, 0, 0, 0, 0, 0);
      chk("stall_frozen", {red, green, blue}, frozen);
    end
    px(261, 200);
    chk("resume_no_drop", {red, green, blue}, WHITE);
    px(262, 200); px(0, 500);

    // Clipping near 1023
    wr(0, 1020); wr(1, 0); fstart();
    for (int x = 0; x < 4; x++) px(160 + x, 2);
    px(0, 500);
    chk("clip_no_wrap", {red, green, blue}, BG);

    // Randomized scenes
    for (int round = 0; round < 30; round++) begin
      case ($urandom_range(0, 2))
        0: bx = $urandom_range(0, 1023);
        1: bx = $urandom_range(8, 28);
        default: bx = $urandom_range(608, 628);
      endcase
      by = $urandom_range(0, 479);
      wr(0, bx); wr(1, by);
      wr(2, by - 70 + $urandom_range(0, 80)); wr(3, by - 70 + $urandom_range(0, 80));
      wr(4, ($urandom_range(0, 4) != 0) ? 1 : 0);
      fstart();
      for (int i = 0; i < 150; i++) begin
        int h, v;
        h = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : 160 + bx - 6 + $urandom_range(0, 20);
        v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : by - 4 + $urandom_range(0, 16);
        step(h, v, $urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0,
             $urandom_range(0, 15) == 0, $urandom_range(0, 7), $urandom, $urandom_range(0, 7));
      end
    end

    // Frame counter wrap
    fsave = fcnt;
    for (int i = 0; i < 256; i++) fstart();
    rd(5);
    chk("frame_count_wrap", 24'(rd_data[15:8]), 24'(8'(fsave)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
